// File: rtl/imem_pkg.sv
// -----------------------------------------------------------------------------
// imem_pkg
// Shared definitions for the instruction memory / fetch unit:
//   - opcode constants (OP_NOP, OP_ADD, OP_SUB)
//   - register identifiers R0..R7
//   - FSM state enum {INIT, RUN}
//   - enc_instr(): packs {op,rd,rs,rt} MSB-aligned into a word of data_w bits,
//     with the unused LSBs left at zero. The result is returned 64 bits wide;
//     callers size-cast it to their own DATA_W.
// -----------------------------------------------------------------------------
package imem_pkg;

    localparam int OP_NOP = 32'sd0;
    localparam int OP_ADD = 32'sd1;
    localparam int OP_SUB = 32'sd2;

    localparam int R0 = 32'sd0;
    localparam int R1 = 32'sd1;
    localparam int R2 = 32'sd2;
    localparam int R3 = 32'sd3;
    localparam int R4 = 32'sd4;
    localparam int R5 = 32'sd5;
    localparam int R6 = 32'sd6;
    localparam int R7 = 32'sd7;

    typedef enum logic {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Fields are concatenated op|rd|rs|rt, then shifted up so op sits at the MSB.
    function automatic logic [63:0] enc_instr(input int op, input int rd,
                                              input int rs, input int rt,
                                              input int data_w, input int op_w,
                                              input int reg_w);
        logic [63:0] w;
        w = 64'(op);
        w = (w << reg_w) | 64'(rd);
        w = (w << reg_w) | 64'(rs);
        w = (w << reg_w) | 64'(rt);
        return w << (data_w - op_w - 3 * reg_w);
    endfunction

endpackage

// File: rtl/imem_boot_rom.sv
// -----------------------------------------------------------------------------
// imem_boot_rom
// Combinational boot program lookup used while the memory is initialised.
//   word 0      : ADD R0,R1,R2
//   word 1      : SUB R0,R1,R2
//   words 2..5  : ADD R0,R1,R2
//   word 6      : SUB R0,R1,R2
//   words 7..   : NOP (all zeros)
// Ports
//   addr_i      in   ADDR_W   word address being initialised
//   boot_word_o out  DATA_W   boot program word for addr_i
// -----------------------------------------------------------------------------
module imem_boot_rom
    import imem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 3,
    parameter int REG_W  = 3
) (
    input  logic [ADDR_W-1:0] addr_i,
    output logic [DATA_W-1:0] boot_word_o
);

    // Address to boot word; anything past the program body is a NOP.
    always_comb begin
        boot_word_o = '0;
        case (32'(addr_i))
            32'd0, 32'd2, 32'd3, 32'd4, 32'd5:
                boot_word_o = DATA_W'(enc_instr(OP_ADD, R0, R1, R2, DATA_W, OP_W, REG_W));
            32'd1, 32'd6:
                boot_word_o = DATA_W'(enc_instr(OP_SUB, R0, R1, R2, DATA_W, OP_W, REG_W));
            default:
                boot_word_o = DATA_W'(enc_instr(OP_NOP, R0, R0, R0, DATA_W, OP_W, REG_W));
        endcase
    end

endmodule

// File: rtl/imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// imem_fetch_unit
// Synchronous instruction memory with a handshaked fetch port and a
// program-load write port. After Reset the memory is filled from the boot ROM,
// one word per cycle (busy=1); then fetches and writes are served.
// Optional build macro: IMEM_FWD_EN -- when defined, a fetch that collides
// with a same-cycle write to the same address returns the write data;
// otherwise it returns the old memory contents (the write still lands).
// Ports
//   Clock        in   1       rising-edge clock
//   Reset        in   1       synchronous, active-high
//   fetch_req    in   1       fetch request
//   fetch_addr   in   ADDR_W  fetch address
//   fetch_stall  in   1       consumer not ready, hold the output
//   fetch_valid  out  1       fetch_data holds a valid instruction
//   fetch_data   out  DATA_W  fetched instruction
//   wr_en        in   1       write strobe
//   wr_addr      in   ADDR_W  write address
//   wr_data      in   DATA_W  write data
//   busy         out  1       boot/init sequence in progress
//   wr_err       out  1       one-cycle pulse: write rejected during INIT
// -----------------------------------------------------------------------------
module imem_fetch_unit
    import imem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 4,
    parameter int OP_W   = 3,
    parameter int REG_W  = 3
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic              fetch_req,
    input  logic [ADDR_W-1:0] fetch_addr,
    input  logic              fetch_stall,
    output logic              fetch_valid,
    output logic [DATA_W-1:0] fetch_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              wr_err
);

    localparam int DEPTH = 2 ** ADDR_W;

    state_e            state_q;
    logic [ADDR_W-1:0] init_ptr_q;
    logic              busy_q;
    logic              fetch_valid_q;
    logic [DATA_W-1:0] fetch_data_q;
    logic              wr_err_q;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [DATA_W-1:0] boot_word_s;
    logic [DATA_W-1:0] rd_data_d;
    logic              accept_s;

    imem_boot_rom #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .OP_W   (OP_W),
        .REG_W  (REG_W)
    ) u_boot_rom (
        .addr_i      (init_ptr_q),
        .boot_word_o (boot_word_s)
    );

    // A held (valid and stalled) output blocks new requests; nothing is queued.
    assign accept_s = (state_q == RUN) && fetch_req && !(fetch_valid_q && fetch_stall);

`ifdef IMEM_FWD_EN
    logic collide_s;
    assign collide_s = (state_q == RUN) && wr_en && (wr_addr == fetch_addr);

    // Read data with same-address write forwarding.
    always_comb begin
        rd_data_d = mem_q[fetch_addr];
        if (collide_s) begin
            rd_data_d = wr_data;
        end else begin
            rd_data_d = mem_q[fetch_addr];
        end
    end
`else
    // Read data straight from the array: a same-cycle write is not yet visible.
    always_comb begin
        rd_data_d = mem_q[fetch_addr];
    end
`endif

    // Memory array: boot fill during INIT, external writes during RUN.
    always_ff @(posedge Clock) begin
        if (!Reset) begin
            if (state_q == INIT) begin
                mem_q[init_ptr_q] <= boot_word_s;
            end else if (wr_en) begin
                mem_q[wr_addr] <= wr_data;
            end
        end
    end

    // Control FSM with registered busy, fetch output and write-error pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q       <= INIT;
            init_ptr_q    <= '0;
            busy_q        <= 1'b1;
            fetch_valid_q <= 1'b0;
            fetch_data_q  <= '0;
            wr_err_q      <= 1'b0;
        end else begin
            case (state_q)
                INIT: begin
                    fetch_valid_q <= 1'b0;
                    wr_err_q      <= wr_en;
                    init_ptr_q    <= init_ptr_q + ADDR_W'(1);
                    // All-ones pointer means the last word is being written now.
                    if (&init_ptr_q) begin
                        state_q <= RUN;
                        busy_q  <= 1'b0;
                    end
                end
                RUN: begin
                    wr_err_q <= 1'b0;
                    busy_q   <= 1'b0;
                    if (accept_s) begin
                        fetch_valid_q <= 1'b1;
                        fetch_data_q  <= rd_data_d;
                    end else if (fetch_valid_q && fetch_stall) begin
                        fetch_valid_q <= 1'b1;
                    end else begin
                        fetch_valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q       <= INIT;
                    init_ptr_q    <= '0;
                    busy_q        <= 1'b1;
                    fetch_valid_q <= 1'b0;
                    wr_err_q      <= 1'b0;
                end
            endcase
        end
    end

    assign fetch_valid = fetch_valid_q;
    assign fetch_data  = fetch_data_q;
    assign busy        = busy_q;
    assign wr_err      = wr_err_q;

endmodule

// File: tb/tb_imem_fetch_unit.sv
// -----------------------------------------------------------------------------
// tb_imem_fetch_unit
// Self-checking bench for imem_fetch_unit (default parameters, DEPTH=16).
// Inputs change on the falling edge; outputs are sampled on the falling edge.
// Expected fetch results are pushed to exp_q when a request is driven and
// popped when the response is due one cycle later. model_mem mirrors the
// memory contents from the boot program plus the writes the bench performs.
// -----------------------------------------------------------------------------
module tb_imem_fetch_unit;

    logic        Clock;
    logic        Reset;
    logic        fetch_req;
    logic [3:0]  fetch_addr;
    logic        fetch_stall;
    logic        fetch_valid;
    logic [15:0] fetch_data;
    logic        wr_en;
    logic [3:0]  wr_addr;
    logic [15:0] wr_data;
    logic        busy;
    logic        wr_err;

    int          total;
    int          bad;
    logic [15:0] model_mem [16];
    logic [15:0] exp_q [$];

    imem_fetch_unit #(
        .DATA_W (16),
        .ADDR_W (4),
        .OP_W   (3),
        .REG_W  (3)
    ) dut (
        .Clock       (Clock),
        .Reset       (Reset),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_data  (fetch_data),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .busy        (busy),
        .wr_err      (wr_err)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Hand-encoded boot program: ADD R0,R1,R2 = 16'h20A0, SUB R0,R1,R2 = 16'h40A0.
    function automatic logic [15:0] boot_val(input int a);
        case (a)
            0, 2, 3, 4, 5: return 16'h20A0;
            1, 6:          return 16'h40A0;
            default:       return 16'h0000;
        endcase
    endfunction

    task automatic load_model();
        for (int i = 0; i < 16; i++) model_mem[i] = boot_val(i);
    endtask

    // Called on the falling edge right after the reset edge, with Reset now low.
    task automatic check_boot(input bit with_write, input string tag);
        logic exp_err;
        for (int i = 0; i < 16; i++) begin
            exp_err = (with_write && i == 13) ? 1'b1 : 1'b0;
            total++;
            if (busy !== 1'b1 || fetch_valid !== 1'b0 || wr_err !== exp_err) begin
                bad++;
                $display("FAIL %s init cyc=%0d busy=%b valid=%b wr_err=%b want busy=1 valid=0 wr_err=%b",
                         tag, i, busy, fetch_valid, wr_err, exp_err);
            end
            fetch_req  = 1'b1;
            fetch_addr = 4'(i);
            wr_en      = (with_write && i == 12) ? 1'b1 : 1'b0;
            wr_addr    = 4'd9;
            wr_data    = 16'hBEEF;
            @(negedge Clock);
        end
        fetch_req = 1'b0;
        wr_en     = 1'b0;
        total++;
        if (busy !== 1'b0 || fetch_valid !== 1'b0 || wr_err !== 1'b0) begin
            bad++;
            $display("FAIL %s boot_end busy=%b valid=%b wr_err=%b want 0 0 0",
                     tag, busy, fetch_valid, wr_err);
        end
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        @(negedge Clock);
        total++;
        if (busy !== 1'b1 || fetch_valid !== 1'b0 || fetch_data !== 16'h0000 || wr_err !== 1'b0) begin
            bad++;
            $display("FAIL reset_state busy=%b valid=%b data=%h wr_err=%b want 1 0 0000 0",
                     busy, fetch_valid, fetch_data, wr_err);
        end
        Reset = 1'b0;
        load_model();
        check_boot(1'b1, "reset");
    endtask

    task automatic test_back_to_back();
        logic [3:0]  addrs [4];
        logic [15:0] exp_d;
        addrs[0] = 4'd0; addrs[1] = 4'd1; addrs[2] = 4'd6; addrs[3] = 4'd7;
        fetch_req  = 1'b1;
        fetch_addr = addrs[0];
        exp_q.push_back(model_mem[addrs[0]]);
        for (int k = 1; k <= 4; k++) begin
            @(negedge Clock);
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL b2b scoreboard empty at k=%0d", k);
            end else begin
                exp_d = exp_q.pop_front();
                if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
                    bad++;
                    $display("FAIL b2b k=%0d valid=%b data=%h want valid=1 data=%h",
                             k, fetch_valid, fetch_data, exp_d);
                end
            end
            if (k < 4) begin
                fetch_addr = addrs[k];
                exp_q.push_back(model_mem[addrs[k]]);
            end else begin
                fetch_req = 1'b0;
            end
        end
        @(negedge Clock);
        total++;
        if (fetch_valid !== 1'b0 || fetch_data !== 16'h0000) begin
            bad++;
            $display("FAIL idle_after_b2b valid=%b data=%h want valid=0 data=0000",
                     fetch_valid, fetch_data);
        end
    endtask

    task automatic test_write_fetch();
        logic [15:0] exp_d;
        // mem[9] must still hold its boot value after the write rejected in INIT.
        fetch_req  = 1'b1;
        fetch_addr = 4'd9;
        exp_q.push_back(model_mem[9]);
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL init_write_dropped valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        fetch_req = 1'b0;
        wr_en     = 1'b1;
        wr_addr   = 4'd9;
        wr_data   = 16'hBEEF;
        model_mem[9] = 16'hBEEF;
        @(negedge Clock);
        wr_en = 1'b0;
        total++;
        if (wr_err !== 1'b0) begin
            bad++;
            $display("FAIL run_write_err wr_err=%b want 0", wr_err);
        end
        fetch_req  = 1'b1;
        fetch_addr = 4'd9;
        exp_q.push_back(model_mem[9]);
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL write_then_fetch valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_stall();
        logic [3:0]  first_a [2];
        logic [3:0]  second_a [2];
        logic [15:0] held;
        logic [15:0] exp_d;
        first_a[0] = 4'd2; second_a[0] = 4'd0;
        first_a[1] = 4'd9; second_a[1] = 4'd1;
        for (int p = 0; p < 2; p++) begin
            fetch_req  = 1'b1;
            fetch_addr = first_a[p];
            held       = model_mem[first_a[p]];
            exp_q.push_back(held);
            @(negedge Clock);
            exp_d = exp_q.pop_front();
            total++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
                bad++;
                $display("FAIL stall_first p=%0d valid=%b data=%h want 1 %h", p, fetch_valid, fetch_data, exp_d);
            end
            fetch_stall = 1'b1;
            fetch_addr  = second_a[p];
            for (int s = 0; s < 3; s++) begin
                @(negedge Clock);
                total++;
                if (fetch_valid !== 1'b1 || fetch_data !== held) begin
                    bad++;
                    $display("FAIL stall_hold p=%0d s=%0d valid=%b data=%h want 1 %h",
                             p, s, fetch_valid, fetch_data, held);
                end
            end
            fetch_stall = 1'b0;
            exp_q.push_back(model_mem[second_a[p]]);
            @(negedge Clock);
            exp_d = exp_q.pop_front();
            total++;
            if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
                bad++;
                $display("FAIL stall_release p=%0d valid=%b data=%h want 1 %h", p, fetch_valid, fetch_data, exp_d);
            end
            fetch_req = 1'b0;
            @(negedge Clock);
        end
    endtask

    task automatic test_collision();
        logic [15:0] exp_d;
        fetch_req  = 1'b1;
        fetch_addr = 4'd3;
        wr_en      = 1'b1;
        wr_addr    = 4'd3;
        wr_data    = 16'h1234;
`ifdef IMEM_FWD_EN
        exp_q.push_back(16'h1234);
`else
        exp_q.push_back(model_mem[3]);
`endif
        model_mem[3] = 16'h1234;
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL collide_same valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        // Write and fetch to different addresses in the same cycle.
        fetch_addr = 4'd5;
        wr_addr    = 4'd4;
        wr_data    = 16'h5555;
        exp_q.push_back(model_mem[5]);
        model_mem[4] = 16'h5555;
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL collide_diff valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        wr_en      = 1'b0;
        fetch_addr = 4'd3;
        exp_q.push_back(model_mem[3]);
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL refetch_3 valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        fetch_addr = 4'd4;
        exp_q.push_back(model_mem[4]);
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL refetch_4 valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        fetch_req = 1'b0;
    endtask

    task automatic test_reset_midrun();
        logic [15:0] exp_d;
        wr_en   = 1'b1;
        wr_addr = 4'd0;
        wr_data = 16'hFFFF;
        model_mem[0] = 16'hFFFF;
        @(negedge Clock);
        wr_en      = 1'b0;
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        exp_q.push_back(model_mem[0]);
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL pre_reset_fetch valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        Reset      = 1'b1;
        fetch_addr = 4'd1;
        @(negedge Clock);
        total++;
        if (fetch_valid !== 1'b0 || busy !== 1'b1 || fetch_data !== 16'h0000) begin
            bad++;
            $display("FAIL midrun_reset valid=%b busy=%b data=%h want 0 1 0000", fetch_valid, busy, fetch_data);
        end
        Reset = 1'b0;
        exp_q.delete();
        load_model();
        check_boot(1'b0, "reboot");
        fetch_req  = 1'b1;
        fetch_addr = 4'd0;
        exp_q.push_back(model_mem[0]);
        @(negedge Clock);
        exp_d = exp_q.pop_front();
        total++;
        if (fetch_valid !== 1'b1 || fetch_data !== exp_d) begin
            bad++;
            $display("FAIL post_reboot_fetch0 valid=%b data=%h want 1 %h", fetch_valid, fetch_data, exp_d);
        end
        fetch_req = 1'b0;
    endtask

    initial begin
        total       = 0;
        bad         = 0;
        Reset       = 1'b1;
        fetch_req   = 1'b0;
        fetch_addr  = 4'd0;
        fetch_stall = 1'b0;
        wr_en       = 1'b0;
        wr_addr     = 4'd0;
        wr_data     = 16'h0000;
        test_reset();
        test_back_to_back();
        test_write_fetch();
        test_stall();
        test_collision();
        test_reset_midrun();
        @(negedge Clock);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog expired");
    end

endmodule
